heading_pid: RTL and testbench
==============================

HEADING_PID -- requirements
Module: heading_pid

Interface
REQ-001 Parameter P_COEFF: 6-bit signed, default 16; proportional gain.
REQ-002 Parameter D_COEFF: 5-bit signed, default 7; derivative gain.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 moving  input  1  robot-moving enable; low forces idle.
REQ-006 err_vld  input  1  single-cycle strobe qualifying error.
REQ-007 error  input  12 signed  heading error sample.
REQ-008 frwrd  input  10 unsigned  forward speed.
REQ-009 lft_spd  output  11 signed  left motor speed command, registered.
REQ-010 rght_spd  output  11 signed  right motor speed command, registered.
REQ-011 spd_vld  output  1  one-cycle pulse marking a new lft_spd/rght_spd pair.
REQ-012 The design SHALL use a single clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-013 Stage 0 SHALL run on a rising edge with err_vld=1 and moving=1.
  - Register e_q = error saturated to 10-bit signed [-512,511].
  - Set v1.
REQ-014 Stage 1 SHALL run on a rising edge with v1=1 and moving=1.
  - p_q = e_q*P_COEFF, 15-bit signed.
  - integ = integ+e_q, 15-bit signed, saturating at +16383/-16384, no wrap.
  - d_q = sat8(e_q-prev2)*D_COEFF: 11-bit difference saturated to [-128,127], result 13-bit signed.
  - Shift history: prev2<=prev1, prev1<=e_q.
  - Set v2.
REQ-015 I_term SHALL be integ[14:6] (9-bit signed), taken after the Stage 1 update.
REQ-016 Stage 2 SHALL run on a rising edge with v2=1 and moving=1.
  - pid = sign-extended p_q + I_term + d_q, 15-bit signed.
  - s = pid>>>3, 12-bit arithmetic shift.
  - lft_spd = sat11(frwrd+s); rght_spd = sat11(frwrd-s).
  - Sums are 13-bit signed; saturate to [-1024,1023].
  - Assert spd_vld for exactly the following cycle.
REQ-017 Latency SHALL be fixed: outputs update on the 3rd rising edge, counting the edge that samples err_vld.
REQ-018 Back-to-back err_vld on every cycle SHALL be accepted with no drops; each sample produces exactly one spd_vld.
REQ-019 Outputs SHALL hold their values between spd_vld pulses; a frwrd change alone does not update them.
REQ-020 On a rising edge with moving=0, the block SHALL clear the following and suppress spd_vld:
  - integ, prev1, prev2, e_q, p_q, d_q, v1, v2;
  - lft_spd and rght_spd, forced to 0.
REQ-021 A moving=0 cycle arriving while v1 or v2 is set SHALL discard in-flight samples; no spd_vld results.
REQ-022 err_vld asserted while moving=0 SHALL be ignored.

Reset
REQ-023 rst_n low SHALL immediately force the following to 0, independent of clk:
  - lft_spd, rght_spd, spd_vld;
  - integ, prev1, prev2, e_q, p_q, d_q, v1, v2.
REQ-024 The first err_vld after rst_n deassertion with moving=1 SHALL be processed normally.

Verification
REQ-025 Reset: assert rst_n low mid-cycle -> lft_spd=0, rght_spd=0, spd_vld=0 before the next clk edge.
REQ-026 Zero error: moving=1, frwrd=256, error=0 strobed -> 3rd edge gives lft_spd=rght_spd=256, one spd_vld pulse.
REQ-027 Single sample from cleared state: frwrd=256, error=+64 -> outputs lft_spd=440, rght_spd=72.
  - Intermediates: P=1024, I=1, D=448, pid=1473, s=184.
REQ-028 Saturation: frwrd=1023, error=2047 -> outputs lft_spd=1023 (saturated), rght_spd=-111.
  - Intermediates: e_q=511, P=8176, I=7, D=889, s=1134.
REQ-029 Integrator limit: moving=1, error=511 strobed 40 consecutive cycles -> integ=16383, I_term=255, no wrap; exactly 40 spd_vld pulses.
REQ-030 Abort: err_vld at edge N, moving=0 at edge N+1 -> no spd_vld, outputs 0, integ=0; next sample behaves as REQ-027.

Source files
------------

// File: rtl/heading_pid.sv
// Three-stage heading PID: error capture, P/I/D term formation, then
// summation and differential steering of the forward speed into motor commands.
module heading_pid #(
    parameter logic signed [5:0] P_COEFF = 6'sd16,
    parameter logic signed [4:0] D_COEFF = 5'sd7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                moving,
    input  logic                err_vld,
    input  logic signed [11:0]  error,
    input  logic        [9:0]   frwrd,
    output logic signed [10:0]  lft_spd,
    output logic signed [10:0]  rght_spd,
    output logic                spd_vld
);

    logic signed [9:0]  e_q, e_d;
    logic signed [9:0]  prev1_q, prev1_d;
    logic signed [9:0]  prev2_q, prev2_d;
    logic signed [14:0] p_q, p_d;
    logic signed [14:0] integ_q, integ_d;
    logic signed [12:0] d_q, d_d;
    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic signed [10:0] lft_q, lft_d;
    logic signed [10:0] rght_q, rght_d;
    logic               spd_vld_q, spd_vld_d;

    logic signed [9:0]  e_sat;
    logic signed [15:0] integ_sum;
    logic signed [10:0] diff;
    logic signed [7:0]  diff_sat;
    logic signed [14:0] pid;
    logic signed [12:0] s_ext;
    logic signed [12:0] lsum;
    logic signed [12:0] rsum;

    always_comb begin
        e_sat     = error[9:0];
        integ_sum = {integ_q[14], integ_q} + {{6{e_q[9]}}, e_q};
        diff      = {e_q[9], e_q} - {prev2_q[9], prev2_q};
        diff_sat  = diff[7:0];
        pid       = p_q + {{6{integ_q[14]}}, integ_q[14:6]} + {{2{d_q[12]}}, d_q};
        s_ext     = 13'(pid >>> 3);
        lsum      = {3'b000, frwrd} + s_ext;
        rsum      = {3'b000, frwrd} - s_ext;

        if (error > 12'sd511) begin
            e_sat = 10'sd511;
        end else if (error < -12'sd512) begin
            e_sat = -10'sd512;
        end
        if (diff > 11'sd127) begin
            diff_sat = 8'sd127;
        end else if (diff < -11'sd128) begin
            diff_sat = -8'sd128;
        end

        e_d       = e_q;
        prev1_d   = prev1_q;
        prev2_d   = prev2_q;
        p_d       = p_q;
        integ_d   = integ_q;
        d_d       = d_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        v1_d      = err_vld;
        v2_d      = v1_q;
        spd_vld_d = v2_q;

        if (err_vld) begin
            e_d = e_sat;
        end

        if (v1_q) begin
            p_d = {{5{e_q[9]}}, e_q} * {{9{P_COEFF[5]}}, P_COEFF};
            d_d = {{5{diff_sat[7]}}, diff_sat} * {{8{D_COEFF[4]}}, D_COEFF};
            if (integ_sum > 16'sd16383) begin
                integ_d = 15'sd16383;
            end else if (integ_sum < -16'sd16384) begin
                integ_d = -15'sd16384;
            end else begin
                integ_d = integ_sum[14:0];
            end
            prev2_d = prev1_q;
            prev1_d = e_q;
        end

        // integ_q is already post-update here, so I_term reflects this sample
        if (v2_q) begin
            if (lsum > 13'sd1023)       lft_d = 11'sd1023;
            else if (lsum < -13'sd1024) lft_d = -11'sd1024;
            else                        lft_d = lsum[10:0];
            if (rsum > 13'sd1023)       rght_d = 11'sd1023;
            else if (rsum < -13'sd1024) rght_d = -11'sd1024;
            else                        rght_d = rsum[10:0];
        end

        // Stopping flushes the pipeline and all history, not just the outputs
        if (!moving) begin
            e_d       = '0;
            prev1_d   = '0;
            prev2_d   = '0;
            p_d       = '0;
            integ_d   = '0;
            d_d       = '0;
            lft_d     = '0;
            rght_d    = '0;
            v1_d      = 1'b0;
            v2_d      = 1'b0;
            spd_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            prev1_q   <= '0;
            prev2_q   <= '0;
            p_q       <= '0;
            integ_q   <= '0;
            d_q       <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            spd_vld_q <= 1'b0;
        end else begin
            e_q       <= e_d;
            prev1_q   <= prev1_d;
            prev2_q   <= prev2_d;
            p_q       <= p_d;
            integ_q   <= integ_d;
            d_q       <= d_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            spd_vld_q <= spd_vld_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign spd_vld  = spd_vld_q;

endmodule

// File: tb/tb_heading_pid.sv
// Directed bench for heading_pid: hand-computed vectors covering reset,
// nominal samples, saturation, integrator limit, abort and output hold.
module tb_heading_pid;

    logic               clk;
    logic               rst_n;
    logic               moving;
    logic               err_vld;
    logic signed [11:0] error;
    logic        [9:0]  frwrd;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               spd_vld;

    int vectors;
    int miscompares;
    int pulse_cnt;
    int pulse_base;

    heading_pid dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (spd_vld === 1'b1) pulse_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample and advance to just after the edge that updates outputs
    task automatic run_sample(input logic signed [11:0] e, input logic [9:0] f);
        frwrd   = f;
        error   = e;
        err_vld = 1'b1;
        step();
        err_vld = 1'b0;
        step();
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        moving      = 1'b0;
        err_vld     = 1'b0;
        error       = '0;
        frwrd       = '0;

        #12;
        check("rst_lft", lft_spd, 0);
        check("rst_rght", rght_spd, 0);
        check("rst_vld", spd_vld, 0);
        step();
        rst_n  = 1'b1;
        moving = 1'b1;
        step();

        pulse_base = pulse_cnt;
        run_sample(12'sd0, 10'd256);
        check("zero_lft", lft_spd, 256);
        check("zero_rght", rght_spd, 256);
        check("zero_vld", spd_vld, 1);
        step();
        check("zero_vld_drop", spd_vld, 0);
        check("zero_pulses", pulse_cnt - pulse_base, 1);

        run_sample(12'sd64, 10'd256);
        check("p64_lft", lft_spd, 440);
        check("p64_rght", rght_spd, 72);
        check("p64_vld", spd_vld, 1);

        frwrd = 10'd500;
        step();
        step();
        step();
        check("hold_lft", lft_spd, 440);
        check("hold_rght", rght_spd, 72);
        check("hold_vld", spd_vld, 0);

        moving = 1'b0;
        step();
        check("stop_lft", lft_spd, 0);
        check("stop_rght", rght_spd, 0);
        moving = 1'b1;

        run_sample(12'sd2047, 10'd1023);
        check("sat_lft", lft_spd, 1023);
        check("sat_rght", rght_spd, -111);

        moving = 1'b0;
        step();
        moving = 1'b1;
        pulse_base = pulse_cnt;
        frwrd   = 10'd100;
        error   = 12'sd511;
        err_vld = 1'b1;
        repeat (40) step();
        err_vld = 1'b0;
        step();
        step();
        check("lim_integ", dut.integ_q, 16383);
        check("lim_lft", lft_spd, 1023);
        check("lim_rght", rght_spd, -953);
        step();
        step();
        check("lim_pulses", pulse_cnt - pulse_base, 40);

        pulse_base = pulse_cnt;
        frwrd   = 10'd256;
        error   = 12'sd64;
        err_vld = 1'b1;
        step();
        moving = 1'b0;
        repeat (4) step();
        err_vld = 1'b0;
        check("abort_pulses", pulse_cnt - pulse_base, 0);
        check("abort_lft", lft_spd, 0);
        check("abort_rght", rght_spd, 0);
        check("abort_integ", dut.integ_q, 0);
        moving = 1'b1;
        run_sample(12'sd64, 10'd256);
        check("post_abort_lft", lft_spd, 440);
        check("post_abort_rght", rght_spd, 72);

        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lft", lft_spd, 0);
        check("mid_rst_rght", rght_spd, 0);
        check("mid_rst_vld", spd_vld, 0);
        step();
        rst_n = 1'b1;
        step();

        run_sample(-12'sd64, 10'd256);
        check("neg64_lft", lft_spd, 71);
        check("neg64_rght", rght_spd, 441);
        check("neg64_vld", spd_vld, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
